// File: rtl/elevator_pkg.sv
//------------------------------------------------------------------------------
// Module   : elevator_pkg
// Brief    : Shared encodings for the elevator dispatcher slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package elevator_pkg;

    typedef logic [1:0] dir_t;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic MOVE  = 1'b1;
    localparam logic HOLD  = 1'b0;

    localparam logic [1:0] STOP   = 2'b00;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] DOWN   = 2'b01;
    localparam logic [1:0] UPDOWN = 2'b11;

endpackage

`default_nettype wire

// File: rtl/elevator_request_latch.sv
//------------------------------------------------------------------------------
// Module   : elevator_request_latch
// Brief    : Pending hall/car call registers with clear-on-door-open and
//            above/below call summaries relative to the current floor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elevator_request_latch #(
    parameter int FLOORS     = 7,
    parameter int FW         = 3,
    parameter int PARK_FLOOR = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [FW-1:0]       currentFloor,
    input  logic [2*FLOORS-1:0] floorButton,
    input  logic [FLOORS-1:0]   internalButton,
    input  logic                clear_en,
    input  logic [1:0]          direction,
    input  logic                park_set,
    output logic [2*FLOORS-1:0] hallPending,
    output logic [FLOORS-1:0]   carPending,
    output logic                anyUpper,
    output logic                anyLower,
    output logic                here_car,
    output logic                here_up,
    output logic                here_down
);
    import elevator_pkg::*;

    logic [FLOORS-1:0]   w_here;
    logic [FLOORS-1:0]   w_above;
    logic [FLOORS-1:0]   w_below;
    logic [FLOORS-1:0]   w_floor_any;
    logic [FLOORS-1:0]   w_car_clr;
    logic [FLOORS-1:0]   w_park_vec;
    logic [FLOORS-1:0]   w_up_here;
    logic [FLOORS-1:0]   w_dn_here;
    logic [2*FLOORS-1:0] w_hall_set;
    logic [2*FLOORS-1:0] w_hall_clr;
    logic                w_clr_up;
    logic                w_clr_dn;

    // A STOP car serves both hall directions at the open door.
    assign w_clr_up = clear_en && (direction == UP   || direction == STOP);
    assign w_clr_dn = clear_en && (direction == DOWN || direction == STOP);

    for (genvar f = 1; f <= FLOORS; f++) begin : g_floor
        assign w_here[f-1]       = (currentFloor == FW'(f));
        assign w_above[f-1]      = (FW'(f) > currentFloor);
        assign w_below[f-1]      = (FW'(f) < currentFloor);
        assign w_floor_any[f-1]  = carPending[f-1] | hallPending[2*f-1] | hallPending[2*f-2];
        assign w_car_clr[f-1]    = clear_en & w_here[f-1];
        assign w_hall_clr[2*f-1] = w_clr_up & w_here[f-1];
        assign w_hall_clr[2*f-2] = w_clr_dn & w_here[f-1];
        // No UP call exists at the top floor, no DOWN call at floor 1.
        assign w_hall_set[2*f-1] = (f != FLOORS) & floorButton[2*f-1];
        assign w_hall_set[2*f-2] = (f != 1) & floorButton[2*f-2];
        assign w_park_vec[f-1]   = park_set & (f == PARK_FLOOR);
        assign w_up_here[f-1]    = hallPending[2*f-1] & w_here[f-1];
        assign w_dn_here[f-1]    = hallPending[2*f-2] & w_here[f-1];
    end

    assign anyUpper  = |(w_floor_any & w_above);
    assign anyLower  = |(w_floor_any & w_below);
    assign here_car  = |(carPending & w_here);
    assign here_up   = |w_up_here;
    assign here_down = |w_dn_here;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hallPending <= '0;
            carPending  <= '0;
        end else if (enable) begin
            hallPending <= (hallPending | w_hall_set) & ~w_hall_clr;
            carPending  <= (carPending | internalButton | w_park_vec) & ~w_car_clr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/elevator_dispatcher.sv
//------------------------------------------------------------------------------
// Module   : elevator_dispatcher
// Brief    : Direction FSM, stop decision, idle parking and floor error flag
//            for a single car.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elevator_dispatcher #(
    parameter int FLOORS     = 7,
    parameter int FW         = 3,
    parameter int PARK_FLOOR = 1,
    parameter int PARK_DELAY = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [FW-1:0]       currentFloor,
    input  logic [2*FLOORS-1:0] floorButton,
    input  logic [FLOORS-1:0]   internalButton,
    input  logic                doorState,
    input  logic                move,
    output logic [1:0]          nextDirection,
    output logic                stopHere,
    output logic [2*FLOORS-1:0] hallPending,
    output logic [FLOORS-1:0]   carPending,
    output logic                floorError
);
    import elevator_pkg::*;

    logic       w_valid;
    logic       w_clear_en;
    logic       w_park_set;
    logic       w_any_pending;
    logic       w_any_upper;
    logic       w_any_lower;
    logic       w_here_car;
    logic       w_here_up;
    logic       w_here_down;
    logic [1:0] w_dir_next;
    logic       w_stop_next;

    assign w_valid       = (currentFloor != '0) && (currentFloor <= FW'(FLOORS));
    assign w_clear_en    = w_valid && (move == HOLD) && (doorState == OPEN);
    assign w_any_pending = (|hallPending) | (|carPending);

    elevator_request_latch #(
        .FLOORS     (FLOORS),
        .FW         (FW),
        .PARK_FLOOR (PARK_FLOOR)
    ) u_latch (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .currentFloor   (currentFloor),
        .floorButton    (floorButton),
        .internalButton (internalButton),
        .clear_en       (w_clear_en),
        .direction      (nextDirection),
        .park_set       (w_park_set),
        .hallPending    (hallPending),
        .carPending     (carPending),
        .anyUpper       (w_any_upper),
        .anyLower       (w_any_lower),
        .here_car       (w_here_car),
        .here_up        (w_here_up),
        .here_down      (w_here_down)
    );

    always_comb begin
        w_dir_next = STOP;
        case (nextDirection)
            UP:      if (w_any_upper) w_dir_next = UP;   else if (w_any_lower) w_dir_next = DOWN;
            DOWN:    if (w_any_lower) w_dir_next = DOWN; else if (w_any_upper) w_dir_next = UP;
            default: if (w_any_upper) w_dir_next = UP;   else if (w_any_lower) w_dir_next = DOWN;
        endcase
    end

    // An opposite-direction hall call is served only when the car turns here.
    always_comb begin
        w_stop_next = 1'b0;
        case (nextDirection)
            UP:      w_stop_next = w_here_car | w_here_up   | (w_here_down & ~w_any_upper);
            DOWN:    w_stop_next = w_here_car | w_here_down | (w_here_up   & ~w_any_lower);
            default: w_stop_next = w_here_car | w_here_up   | w_here_down;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nextDirection <= STOP;
            stopHere      <= 1'b0;
            floorError    <= 1'b0;
        end else if (enable) begin
            floorError <= floorError | ~w_valid;
            stopHere   <= w_valid & w_stop_next;
            if (!w_valid) begin
                nextDirection <= STOP;
            end else if ((move == HOLD) && (doorState == CLOSE)) begin
                nextDirection <= w_dir_next;
            end
        end
    end

    if (PARK_DELAY > 0) begin : g_park
        localparam int             IW          = $clog2(PARK_DELAY + 1);
        localparam logic [IW-1:0]  c_park_max  = IW'(PARK_DELAY);
        localparam logic [IW-1:0]  c_park_last = IW'(PARK_DELAY - 1);

        logic [IW-1:0] r_idle;
        logic          w_idle;
        logic          w_fire;

        assign w_idle = (nextDirection == STOP) && !w_any_pending && (doorState == CLOSE);
        // Fires on the cycle the count reaches PARK_DELAY; at the park floor it saturates instead.
        assign w_fire = enable && w_idle && (r_idle == c_park_last)
                        && (currentFloor != FW'(PARK_FLOOR));
        assign w_park_set = w_fire;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_idle <= '0;
            end else if (enable) begin
                if (!w_idle || w_fire) begin
                    r_idle <= '0;
                end else if (r_idle != c_park_max) begin
                    r_idle <= r_idle + IW'(1);
                end
            end
        end
    end else begin : g_no_park
        assign w_park_set = 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
//------------------------------------------------------------------------------
// Module   : tb_elevator_dispatcher
// Brief    : Directed self-checking bench for elevator_dispatcher.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_elevator_dispatcher;

    localparam logic [1:0] D_STOP = 2'b00;
    localparam logic [1:0] D_UP   = 2'b10;
    localparam logic [1:0] D_DOWN = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [2:0]  currentFloor = 3'd1;
    logic [13:0] floorButton = '0;
    logic [6:0]  internalButton = '0;
    logic        doorState = 1'b0;
    logic        move = 1'b0;
    logic [1:0]  nextDirection;
    logic        stopHere;
    logic [13:0] hallPending;
    logic [6:0]  carPending;
    logic        floorError;

    logic [3:0]  floor12 = 4'd5;
    logic [23:0] fb12 = '0;
    logic [11:0] ib12 = '0;
    logic [1:0]  dir12;
    logic        stop12;
    logic [23:0] hall12;
    logic [11:0] car12;
    logic        err12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elevator_dispatcher #(.FLOORS(7), .FW(3), .PARK_FLOOR(1), .PARK_DELAY(8)) dut (
        .clk(clk), .reset(rst), .enable(enable), .currentFloor(currentFloor),
        .floorButton(floorButton), .internalButton(internalButton),
        .doorState(doorState), .move(move), .nextDirection(nextDirection),
        .stopHere(stopHere), .hallPending(hallPending), .carPending(carPending),
        .floorError(floorError)
    );

    elevator_dispatcher #(.FLOORS(12), .FW(4), .PARK_FLOOR(1), .PARK_DELAY(0)) dut12 (
        .clk(clk), .reset(rst), .enable(1'b1), .currentFloor(floor12),
        .floorButton(fb12), .internalButton(ib12),
        .doorState(1'b0), .move(1'b0), .nextDirection(dir12),
        .stopHere(stop12), .hallPending(hall12), .carPending(car12),
        .floorError(err12)
    );

    typedef struct {
        logic [2:0]  floor;
        logic [13:0] fb;
        logic [6:0]  ib;
        logic        door;
        logic        mv;
        logic [1:0]  e_dir;
        logic        e_stop;
        logic [13:0] e_hall;
        logic [6:0]  e_car;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // floor, fb, ib, door, move | dir, stop, hall, car
        vecs[0]  = '{3'd1, 14'h0000, 7'h10, 1'b0, 1'b0, D_STOP, 1'b0, 14'h0000, 7'h10};
        vecs[1]  = '{3'd1, 14'h0000, 7'h00, 1'b0, 1'b0, D_UP,   1'b0, 14'h0000, 7'h10};
        vecs[2]  = '{3'd2, 14'h0000, 7'h00, 1'b0, 1'b1, D_UP,   1'b0, 14'h0000, 7'h10};
        vecs[3]  = '{3'd3, 14'h0408, 7'h00, 1'b0, 1'b1, D_UP,   1'b0, 14'h0408, 7'h10};
        vecs[4]  = '{3'd4, 14'h0000, 7'h00, 1'b0, 1'b1, D_UP,   1'b0, 14'h0408, 7'h10};
        vecs[5]  = '{3'd5, 14'h0000, 7'h00, 1'b0, 1'b0, D_UP,   1'b1, 14'h0408, 7'h10};
        vecs[6]  = '{3'd5, 14'h0000, 7'h00, 1'b1, 1'b0, D_UP,   1'b1, 14'h0408, 7'h00};
        vecs[7]  = '{3'd5, 14'h0000, 7'h00, 1'b0, 1'b0, D_UP,   1'b0, 14'h0408, 7'h00};
        vecs[8]  = '{3'd6, 14'h0000, 7'h00, 1'b0, 1'b0, D_DOWN, 1'b1, 14'h0408, 7'h00};
        vecs[9]  = '{3'd6, 14'h0000, 7'h00, 1'b1, 1'b0, D_DOWN, 1'b1, 14'h0008, 7'h00};
        vecs[10] = '{3'd6, 14'h0000, 7'h00, 1'b0, 1'b0, D_DOWN, 1'b0, 14'h0008, 7'h00};
        vecs[11] = '{3'd2, 14'h0000, 7'h00, 1'b0, 1'b0, D_STOP, 1'b1, 14'h0008, 7'h00};
        vecs[12] = '{3'd2, 14'h0000, 7'h00, 1'b1, 1'b0, D_STOP, 1'b1, 14'h0000, 7'h00};
        vecs[13] = '{3'd2, 14'h3001, 7'h00, 1'b0, 1'b0, D_STOP, 1'b0, 14'h1000, 7'h00};
        vecs[14] = '{3'd2, 14'h0000, 7'h00, 1'b0, 1'b0, D_UP,   1'b0, 14'h1000, 7'h00};
        vecs[15] = '{3'd4, 14'h00C0, 7'h00, 1'b1, 1'b0, D_UP,   1'b0, 14'h1040, 7'h00};
        vecs[16] = '{3'd4, 14'h0000, 7'h00, 1'b0, 1'b0, D_UP,   1'b0, 14'h1040, 7'h00};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset dir",   nextDirection, D_STOP);
        check("reset stop",  stopHere, 0);
        check("reset hall",  hallPending, 0);
        check("reset car",   carPending, 0);
        check("reset err",   floorError, 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            currentFloor   = vecs[i].floor;
            floorButton    = vecs[i].fb;
            internalButton = vecs[i].ib;
            doorState      = vecs[i].door;
            move           = vecs[i].mv;
            tick();
            check($sformatf("vec%0d dir",  i), nextDirection, vecs[i].e_dir);
            check($sformatf("vec%0d stop", i), stopHere,      vecs[i].e_stop);
            check($sformatf("vec%0d hall", i), hallPending,   vecs[i].e_hall);
            check($sformatf("vec%0d car",  i), carPending,    vecs[i].e_car);
        end
        floorButton = '0;

        // Idle parking from floor 4
        currentFloor = 3'd4; doorState = 1'b0; move = 1'b0;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("park car cycle%0d", k), carPending, (k == 8) ? 7'h01 : 7'h00);
        end
        check("park dir before", nextDirection, D_STOP);
        tick();
        check("park dir after", nextDirection, D_DOWN);

        // Invalid floor while travelling UP
        currentFloor = 3'd1;
        do_reset();
        internalButton = 7'h10;
        tick();
        internalButton = 7'h00;
        tick();
        check("err pre dir", nextDirection, D_UP);
        currentFloor = 3'd0; move = 1'b1; internalButton = 7'h20;
        tick();
        check("err flag", floorError, 1);
        check("err dir", nextDirection, D_STOP);
        check("err latch", carPending, 7'h30);
        currentFloor = 3'd3; move = 1'b0; internalButton = 7'h00;
        tick();
        check("err sticky1", floorError, 1);
        tick();
        check("err sticky2", floorError, 1);

        // Enable low holds state
        enable = 1'b0; internalButton = 7'h40;
        tick();
        check("enable hold car", carPending, 7'h30);
        enable = 1'b1; internalButton = 7'h00;

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async dir", nextDirection, D_STOP);
        check("async err", floorError, 0);
        check("async car", carPending, 0);
        @(negedge clk);
        rst = 1'b0;

        // 12-floor build with parking disabled
        repeat (20) tick();
        check("f12 no park car", car12, 0);
        check("f12 idle dir", dir12, D_STOP);
        floor12 = 4'd1; fb12 = 24'h800001; ib12 = 12'h800;
        tick();
        check("f12 hall ignored", hall12, 0);
        check("f12 car", car12, 12'h800);
        fb12 = '0; ib12 = '0;
        tick();
        check("f12 dir", dir12, D_UP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
